// File: rtl/lockin_pkg.sv
// Shared lock-in constants, FSM encoding and TC-to-shift mapping; the UI imports this for gain/TC meaning.
// Gain scales the product by 2^(4*gain); TC selects filter shift k = TC + TC_OFFSET.
package lockin_pkg;

    localparam int SAMPLE_W  = 16;
    localparam int REF_W     = 16;
    localparam int ACC_W     = 48;
    localparam int OUT_W     = 32;
    localparam int TC_OFFSET = 4;
    localparam int OUT_LSB   = 12;
    localparam int PROD_W    = SAMPLE_W + REF_W;
    localparam int K_W       = 5;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_MUL_X = 3'd1,
        ST_MUL_Y = 3'd2,
        ST_LPF1  = 3'd3,
        ST_LPF2  = 3'd4
    } state_t;

    function automatic logic [K_W-1:0] tc_to_shift(input logic [3:0] tc);
        return K_W'(tc) + K_W'(TC_OFFSET);
    endfunction

endpackage

// File: rtl/lpf_stage.sv
// One first-order IIR stage: acc += (in - acc) >>> k on en_i, floor rounding, difference kept at ACC_W+1 bits.
// Single-cycle update; acc_nxt_o exposes the value being written so the caller can register it on the same edge.
module lpf_stage
    import lockin_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en_i,
    input  logic signed [ACC_W-1:0] in_i,
    input  logic [K_W-1:0]          k_i,
    output logic signed [ACC_W-1:0] acc_o,
    output logic signed [ACC_W-1:0] acc_nxt_o
);

    logic signed [ACC_W-1:0] acc_q;
    logic signed [ACC_W-1:0] acc_d;
    logic signed [ACC_W:0]   diff;
    logic signed [ACC_W:0]   step;
    logic                    unused_step_msb;

    always_comb begin
        diff  = {in_i[ACC_W-1], in_i} - {acc_q[ACC_W-1], acc_q};
        step  = diff >>> k_i;
        // k >= TC_OFFSET keeps the step within ACC_W bits, so the top bit is redundant.
        acc_d = en_i ? (acc_q + step[ACC_W-1:0]) : acc_q;
    end

    assign unused_step_msb = step[ACC_W];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc_o     = acc_q;
    assign acc_nxt_o = acc_d;

endmodule

// File: rtl/lockin_demod_lpf.sv
// Lock-in demodulator: shared multiplier, gain shift, IIR low-pass (two stages when LPF_STAGE2_EN is defined).
// Accept->X/Y registered after 4 edges (3 without stage 2); ready only in IDLE, strobes while busy are dropped with overrun.
module lockin_demod_lpf
    import lockin_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst,
    input  logic signed [SAMPLE_W-1:0] sample,
    input  logic signed [REF_W-1:0]    ref_cos,
    input  logic signed [REF_W-1:0]    ref_sin,
    input  logic                       sample_valid,
    input  logic [1:0]                 gain,
    input  logic [3:0]                 TC,
    output logic                       ready,
    output logic signed [OUT_W-1:0]    X,
    output logic signed [OUT_W-1:0]    Y,
    output logic                       out_valid,
    output logic                       overrun
);

    state_t                     state_q;
    logic signed [SAMPLE_W-1:0] sample_q;
    logic signed [REF_W-1:0]    cos_q;
    logic signed [REF_W-1:0]    sin_q;
    logic [1:0]                 gain_q;
    logic [3:0]                 tc_q;
    logic signed [PROD_W-1:0]   prodx_q;
    logic signed [PROD_W-1:0]   prody_q;
    logic signed [OUT_W-1:0]    x_q;
    logic signed [OUT_W-1:0]    y_q;
    logic                       out_valid_q;
    logic                       overrun_q;

    logic signed [REF_W-1:0]    mul_b;
    logic signed [PROD_W-1:0]   prod;
    logic [3:0]                 shamt;
    logic [K_W-1:0]             k;
    logic signed [ACC_W-1:0]    in_x;
    logic signed [ACC_W-1:0]    in_y;
    logic signed [ACC_W-1:0]    acc1x_q;
    logic signed [ACC_W-1:0]    acc1y_q;
    logic signed [ACC_W-1:0]    acc1x_nxt;
    logic signed [ACC_W-1:0]    acc1y_nxt;
    logic signed [ACC_W-1:0]    res_x;
    logic signed [ACC_W-1:0]    res_y;
    logic                       unused_cfg;
    logic                       unused_bits;

    // One multiplier serves both channels; the operand follows the FSM phase.
    assign mul_b = (state_q == ST_MUL_X) ? cos_q : sin_q;
    assign prod  = PROD_W'(sample_q) * PROD_W'(mul_b);
    assign shamt = {gain_q, 2'b00};
    assign in_x  = ACC_W'(prodx_q) <<< shamt;
    assign in_y  = ACC_W'(prody_q) <<< shamt;
    assign k     = tc_to_shift(tc_q);

    lpf_stage u_lpf1_x (
        .clk(clk), .rst(rst), .en_i(state_q == ST_LPF1), .in_i(in_x), .k_i(k),
        .acc_o(acc1x_q), .acc_nxt_o(acc1x_nxt)
    );
    lpf_stage u_lpf1_y (
        .clk(clk), .rst(rst), .en_i(state_q == ST_LPF1), .in_i(in_y), .k_i(k),
        .acc_o(acc1y_q), .acc_nxt_o(acc1y_nxt)
    );

`ifdef LPF_STAGE2_EN
    logic signed [ACC_W-1:0] acc2x_q;
    logic signed [ACC_W-1:0] acc2y_q;

    lpf_stage u_lpf2_x (
        .clk(clk), .rst(rst), .en_i(state_q == ST_LPF2), .in_i(acc1x_q), .k_i(k),
        .acc_o(acc2x_q), .acc_nxt_o(res_x)
    );
    lpf_stage u_lpf2_y (
        .clk(clk), .rst(rst), .en_i(state_q == ST_LPF2), .in_i(acc1y_q), .k_i(k),
        .acc_o(acc2y_q), .acc_nxt_o(res_y)
    );

    assign unused_cfg = ^{acc1x_nxt, acc1y_nxt, acc2x_q, acc2y_q};
`else
    assign res_x      = acc1x_nxt;
    assign res_y      = acc1y_nxt;
    assign unused_cfg = ^{acc1x_q, acc1y_q};
`endif

    // The filter never leaves the input range, so dropping the top bits is exact.
    assign unused_bits = ^{res_x[ACC_W-1:OUT_LSB+OUT_W], res_x[OUT_LSB-1:0],
                           res_y[ACC_W-1:OUT_LSB+OUT_W], res_y[OUT_LSB-1:0]};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            sample_q    <= '0;
            cos_q       <= '0;
            sin_q       <= '0;
            gain_q      <= '0;
            tc_q        <= '0;
            prodx_q     <= '0;
            prody_q     <= '0;
            x_q         <= '0;
            y_q         <= '0;
            out_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            out_valid_q <= 1'b0;
            overrun_q   <= sample_valid && (state_q != ST_IDLE);
            case (state_q)
                ST_IDLE: begin
                    if (sample_valid) begin
                        sample_q <= sample;
                        cos_q    <= ref_cos;
                        sin_q    <= ref_sin;
                        gain_q   <= gain;
                        tc_q     <= TC;
                        state_q  <= ST_MUL_X;
                    end
                end
                ST_MUL_X: begin
                    prodx_q <= prod;
                    state_q <= ST_MUL_Y;
                end
                ST_MUL_Y: begin
                    prody_q <= prod;
                    state_q <= ST_LPF1;
                end
`ifdef LPF_STAGE2_EN
                ST_LPF1: begin
                    state_q <= ST_LPF2;
                end
                ST_LPF2: begin
                    x_q         <= res_x[OUT_LSB+OUT_W-1:OUT_LSB];
                    y_q         <= res_y[OUT_LSB+OUT_W-1:OUT_LSB];
                    out_valid_q <= 1'b1;
                    state_q     <= ST_IDLE;
                end
`else
                ST_LPF1: begin
                    x_q         <= res_x[OUT_LSB+OUT_W-1:OUT_LSB];
                    y_q         <= res_y[OUT_LSB+OUT_W-1:OUT_LSB];
                    out_valid_q <= 1'b1;
                    state_q     <= ST_IDLE;
                end
`endif
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign ready     = (state_q == ST_IDLE);
    assign X         = x_q;
    assign Y         = y_q;
    assign out_valid = out_valid_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_lockin_demod_lpf.sv
// Bench for lockin_demod_lpf: transaction-level filter model compared every cycle, plus literal scenario checks.
module tb_lockin_demod_lpf;

`ifdef LPF_STAGE2_EN
    localparam int LAT = 4;
    localparam int PER = 5;
    localparam bit TWO = 1'b1;
`else
    localparam int LAT = 3;
    localparam int PER = 4;
    localparam bit TWO = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic signed [15:0] sample = '0;
    logic signed [15:0] ref_cos = '0;
    logic signed [15:0] ref_sin = '0;
    logic               sample_valid = 1'b0;
    logic [1:0]         gain = '0;
    logic [3:0]         TC = '0;
    logic               ready;
    logic signed [31:0] X;
    logic signed [31:0] Y;
    logic               out_valid;
    logic               overrun;

    int checks = 0;
    int passed = 0;

    lockin_demod_lpf dut (
        .clk(clk), .rst(rst), .sample(sample), .ref_cos(ref_cos), .ref_sin(ref_sin),
        .sample_valid(sample_valid), .gain(gain), .TC(TC), .ready(ready),
        .X(X), .Y(Y), .out_valid(out_valid), .overrun(overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s actual=%0d required=%0d at t=%0t", nm, act, exp, $time);
    endtask

    // ---------------- behavioural model (per accepted sample, plain integer maths) ----------------
    longint n = 0, busy_until = 0, pend_edge = 0;
    longint a1x = 0, a1y = 0, a2x = 0, a2y = 0, pend_x = 0, pend_y = 0;
    longint m_inx, m_iny;
    int     m_k;
    bit     pend = 1'b0;
    longint exp_x = 0, exp_y = 0;
    bit     exp_ov = 1'b0, exp_ovr = 1'b0, exp_ready = 1'b1;

    function automatic longint iir(input longint acc, input longint target, input int sh);
        return acc + ((target - acc) >>> sh);
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            n = 0; busy_until = 0; pend = 1'b0;
            a1x = 0; a1y = 0; a2x = 0; a2y = 0;
            exp_x = 0; exp_y = 0; exp_ov = 1'b0; exp_ovr = 1'b0; exp_ready = 1'b1;
        end else begin
            n++;
            exp_ov = 1'b0;
            exp_ovr = 1'b0;
            if (sample_valid) begin
                if (n >= busy_until) begin
                    m_k   = int'(TC) + 4;
                    m_inx = longint'(sample) * longint'(ref_cos) * (longint'(1) << (4 * gain));
                    m_iny = longint'(sample) * longint'(ref_sin) * (longint'(1) << (4 * gain));
                    a1x = iir(a1x, m_inx, m_k);
                    a1y = iir(a1y, m_iny, m_k);
                    a2x = iir(a2x, a1x, m_k);
                    a2y = iir(a2y, a1y, m_k);
                    pend_x = (TWO ? a2x : a1x) >>> 12;
                    pend_y = (TWO ? a2y : a1y) >>> 12;
                    pend = 1'b1;
                    pend_edge = n + LAT;
                    busy_until = n + PER;
                end else begin
                    exp_ovr = 1'b1;
                end
            end
            if (pend && n == pend_edge) begin
                exp_x = pend_x; exp_y = pend_y; exp_ov = 1'b1; pend = 1'b0;
            end
            exp_ready = (n + 1 >= busy_until);
        end
    end

    always @(negedge clk) begin
        chk("ready", longint'(ready), longint'(exp_ready));
        chk("out_valid", longint'(out_valid), longint'(exp_ov));
        chk("overrun", longint'(overrun), longint'(exp_ovr));
        chk("X", longint'(X), exp_x);
        chk("Y", longint'(Y), exp_y);
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic send(input int s, input int c, input int sn, input int g, input int tc);
        sample = 16'(s); ref_cos = 16'(c); ref_sin = 16'(sn); gain = 2'(g); TC = 4'(tc);
        sample_valid = 1'b1;
        tick();
        sample_valid = 1'b0;
    endtask

    task automatic wait_out(input string nm, output int lat);
        lat = -1;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (out_valid) begin
                lat = i;
                break;
            end
        end
        if (lat < 0) chk(nm, longint'(out_valid), 1);
        for (int i = 0; i < 10 && !ready; i++) tick();
    endtask

    task automatic send_wait(input int s, input int c, input int sn, input int g, input int tc);
        int lat;
        send(s, c, sn, g, tc);
        wait_out("out_valid_seen", lat);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
    endtask

    int     lat;
    longint maxx;

    initial begin
        // Reset with a strobe held: nothing may come out.
        sample = 16'sd1000; ref_cos = 16'sd16384; sample_valid = 1'b1;
        repeat (3) tick();
        chk("rst_out_valid", longint'(out_valid), 0);
        chk("rst_X", longint'(X), 0);
        sample_valid = 1'b0;
        rst = 1'b1;
        tick();
        chk("rst_ready", longint'(ready), 1);

        // First-sample step and latency.
        send(1000, 16384, 0, 0, 0);
        wait_out("step_seen", lat);
        chk("step_latency", lat, LAT);
        chk("step_X", longint'(X), TWO ? 15 : 250);
        chk("step_Y", longint'(Y), 0);

        // Reset while in LPF1: no output, accumulators cleared.
        send(1000, 16384, 0, 0, 0);
        tick();
        tick();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        repeat (8) tick();
        chk("midrst_X", longint'(X), 0);
        chk("midrst_Y", longint'(Y), 0);
        send_wait(1000, 16384, 0, 0, 0);
        chk("midrst_acc_cleared_X", longint'(X), TWO ? 15 : 250);

        // Convergence. Floor rounding leaves a positive target settling at most one LSB short.
        do_reset();
        maxx = -(longint'(1) << 40);
        repeat (2000) begin
            send_wait(1000, 16384, 0, 0, 0);
            if (longint'(X) > maxx) maxx = longint'(X);
        end
        chk("conv_g0_near_4000", longint'(X >= 3999 && X <= 4000), 1);
        chk("conv_g0_max_le_4000", longint'(maxx <= 4000), 1);

        do_reset();
        maxx = -(longint'(1) << 40);
        repeat (2000) begin
            send_wait(1000, 16384, 0, 3, 0);
            if (longint'(X) > maxx) maxx = longint'(X);
        end
        chk("conv_g3_near_16384000", longint'(X >= 16383999 && X <= 16384000), 1);
        chk("conv_g3_max_le_16384000", longint'(maxx <= 16384000), 1);

        // Quadrature with negative sample: approaches from above, so settles exactly.
        do_reset();
        repeat (2000) send_wait(-1000, 0, 16384, 0, 0);
        chk("quad_X", longint'(X), 0);
        chk("quad_Y", longint'(Y), -4000);

        // Overrun: strobes at E0 and E2, then E5.
        do_reset();
        sample = 16'sd1000; ref_cos = 16'sd16384; ref_sin = 16'sd0; gain = 2'd0; TC = 4'd0;
        sample_valid = 1'b1;
        tick();
        sample_valid = 1'b0;
        tick();
        sample_valid = 1'b1;
        tick();
        chk("ovr_after_E2", longint'(overrun), 1);
        sample_valid = 1'b0;
        tick();
        chk("ovr_one_cycle", longint'(overrun), 0);
        tick();
        sample_valid = 1'b1;
        tick();
        sample_valid = 1'b0;
        chk("E5_no_overrun", longint'(overrun), 0);
        chk("E5_accepted", longint'(ready), 0);
        for (int i = 0; i < 10 && !ready; i++) tick();

        // TC changed during MUL_Y affects only the next sample.
        do_reset();
        sample = 16'sd1000; ref_cos = 16'sd16384; ref_sin = 16'sd0; gain = 2'd0; TC = 4'd0;
        sample_valid = 1'b1;
        tick();
        sample_valid = 1'b0;
        tick();
        TC = 4'd15;
        wait_out("tc_cur_seen", lat);
        chk("tc_cur_X", longint'(X), TWO ? 15 : 250);
        send_wait(1000, 16384, 0, 0, 15);
        chk("tc_next_X", longint'(X), TWO ? 15 : 250);

        // Randomized traffic with mid-operation setting changes.
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            sample_valid = ($urandom_range(0, 9) < 4);
            sample  = 16'($urandom);
            ref_cos = 16'($urandom);
            ref_sin = 16'($urandom);
            if ($urandom_range(0, 15) == 0) begin
                sample = 16'sh8000; ref_cos = 16'sh8000; ref_sin = 16'sh8000;
            end
            gain = 2'($urandom_range(0, 3));
            TC   = 4'($urandom_range(0, 15));
            tick();
        end
        sample_valid = 1'b0;
        repeat (10) tick();

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d passed=%0d", checks, passed);
        $fatal(1);
    end

endmodule
